jpeg_stream_reader: RTL and testbench
=====================================

JPEG_STREAM_READER -- requirements
Module: jpeg_stream_reader

Interface
REQ-001 Parameter BASE_ADDR, 32'h0, byte base address of the JPEG encoder peripheral window on the XBAR bus.
REQ-002 Parameter MASTER_ID, 0, value driven on id; responses with any other r_id are ignored.
REQ-003 Parameter OUT_DEPTH, 4, output buffer entries; power of two, >= 2.
REQ-004 The block SHALL have one clock, clk; rst is synchronous, active-high.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle pulse that begins a drain session; ignored while busy.
REQ-008 busy  out  1  high from the cycle after an accepted start until done or abort.
REQ-009 done  out  1  one-cycle pulse when the final beat is accepted on the stream.
REQ-010 err  out  1  sticky abort flag; cleared by start.
REQ-011 end_interrupt, error_interrupt  in  1 each  encoder end-of-stream pulse and FIFO-full error level.
REQ-012 req, add[31:0], wen, wdata[31:0], be[3:0], id  out  bus request; wen always 1 (read), wdata 0, be 4'hF.
REQ-013 gnt, r_valid, r_rdata[31:0], r_id  in  bus grant and response.
REQ-014 m_valid, m_data[31:0], m_last, m_last_bits[4:0]  out; m_ready  in  valid/ready bitstream output.
REQ-015 word_count  out  16  count of beats accepted on the stream this session.

Function
REQ-016 Register addresses: data BASE_ADDR+0x000, depth BASE_ADDR+0x200, end-bit-count BASE_ADDR+0x300.
REQ-017 Bus: req and add held stable until the gnt cycle; at most one read outstanding; the response is the first r_valid with r_id==MASTER_ID after grant, normally the next cycle.
REQ-018 States: IDLE, POLL_REQ, POLL_WAIT, DATA_REQ, DATA_WAIT, END_REQ, END_WAIT, FLUSH.
REQ-019 IDLE: start -> POLL_REQ; clears err, eof_seen, word_count, hold register and output buffer.
REQ-020 eof_seen is set by end_interrupt in any non-IDLE state; the POLL_REQ grant cycle snapshots eof_seen into eof_at_poll.
REQ-021 POLL_WAIT: d = r_rdata[4:0]; d>0 -> remaining=d, DATA_REQ; d==0 and eof_at_poll -> END_REQ; otherwise -> POLL_REQ.
REQ-022 DATA_REQ asserts req only when the output buffer has at least one free entry; otherwise req stays low.
REQ-023 DATA_WAIT: the returned word enters the hold register; a previously valid hold word is pushed to the output buffer with m_last=0 in the same cycle; remaining decrements; remaining==0 -> POLL_REQ, else DATA_REQ.
REQ-024 END_WAIT captures eof_bits = r_rdata[4:0] -> FLUSH.
REQ-025 FLUSH pushes the hold word with m_last=1, m_last_bits=eof_bits; with no hold word, it pushes a single beat with m_data=0, m_last=1, m_last_bits=0.
REQ-026 done pulses in the cycle after m_valid&m_ready&m_last; busy falls in the same cycle; next state IDLE.
REQ-027 m_data, m_last and m_last_bits stay stable while m_valid & !m_ready; the output buffer never overflows under indefinite backpressure.
REQ-028 m_last_bits is 0 on every beat except the last.
REQ-029 word_count increments on each stream handshake and saturates at 16'hFFFF.
REQ-030 error_interrupt high while busy: err=1; the block waits for any outstanding response, discards it, flushes the hold register and output buffer, goes to IDLE with no done pulse.
REQ-031 Simultaneous push and pop on a full output buffer is allowed; the count is unchanged.

Reset
REQ-032 Synchronous reset -> IDLE; req, busy, done, err, m_valid, m_last, m_last_bits, word_count = 0; add = 0; buffers empty.
REQ-033 Reset mid-session abandons any outstanding read; the response, if one arrives, is ignored.

Verification
REQ-034 Depth replies 3, then 0 with end_interrupt pulsed before the second poll, data 0xA,0xB,0xC, end count 17 -> beats A,B,C; C has m_last=1 and m_last_bits=17; done pulse; word_count=3.
REQ-035 end_interrupt pulses between the depth-poll grant and the depth=0 response -> the block re-polls and does not read END before the next depth=0 poll.
REQ-036 m_ready held low, 10 words available -> exactly OUT_DEPTH+1 data reads issue, then req stays low; after m_ready is released, all 10 words appear in order.
REQ-037 Zero data words, eof seen, end count 0 -> single beat m_data=0, m_last=1; done.
REQ-038 error_interrupt during DATA_WAIT -> err=1, buffers cleared, no done, busy=0; the next start clears err.
REQ-039 rst asserted mid-DATA_WAIT -> all outputs 0 next cycle; the late r_valid produces no beat.

Source files
------------

// File: rtl/jpeg_stream_reader.sv
// Drains a JPEG encoder's output FIFO over the XBAR read bus and re-emits it as a
// valid/ready bitstream, tagging the final beat with the encoder's end-bit count.
module jpeg_stream_reader #(
    parameter logic [31:0]         BASE_ADDR = 32'h0,
    parameter int unsigned         ID_W      = 4,
    parameter logic [ID_W-1:0]     MASTER_ID = '0,
    parameter int unsigned         OUT_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            err,
    input  logic            end_interrupt,
    input  logic            error_interrupt,
    output logic            req,
    output logic [31:0]     add,
    output logic            wen,
    output logic [31:0]     wdata,
    output logic [3:0]      be,
    output logic [ID_W-1:0] id,
    input  logic            gnt,
    input  logic            r_valid,
    input  logic [31:0]     r_rdata,
    input  logic [ID_W-1:0] r_id,
    output logic            m_valid,
    output logic [31:0]     m_data,
    output logic            m_last,
    output logic [4:0]      m_last_bits,
    input  logic            m_ready,
    output logic [15:0]     word_count
);

    localparam int unsigned AW = $clog2(OUT_DEPTH);
    localparam logic [AW:0] DepthC = (AW + 1)'(OUT_DEPTH);

    typedef enum logic [3:0] {
        StIdle, StPollReq, StPollWait, StDataReq, StDataWait,
        StEndReq, StEndWait, StFlush, StAbort
    } state_e;

    state_e          state_q, state_d;
    logic            err_q, err_d, done_q, done_d;
    logic            eof_seen_q, eof_seen_d, eof_at_poll_q, eof_at_poll_d;
    logic [4:0]      remaining_q, remaining_d, eof_bits_q, eof_bits_d;
    logic [31:0]     hold_q, hold_d;
    logic            hold_v_q, hold_v_d, last_pushed_q, last_pushed_d;
    logic [15:0]     wcnt_q, wcnt_d;
    logic [31:0]     mem_q [OUT_DEPTH];
    logic [31:0]     mem_d [OUT_DEPTH];
    logic            last_q [OUT_DEPTH];
    logic            last_d [OUT_DEPTH];
    logic [4:0]      bits_q [OUT_DEPTH];
    logic [4:0]      bits_d [OUT_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;

    logic        rsp, pop, fifo_free, push, push_last, clear, outstanding, req_int;
    logic [31:0] push_data, addr;
    logic [4:0]  push_bits;

    assign rsp       = r_valid && (r_id == MASTER_ID);
    assign m_valid   = (cnt_q != '0);
    assign pop       = m_valid && m_ready;
    assign fifo_free = (cnt_q != DepthC);

    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        done_d        = 1'b0;
        eof_seen_d    = eof_seen_q;
        eof_at_poll_d = eof_at_poll_q;
        remaining_d   = remaining_q;
        eof_bits_d    = eof_bits_q;
        hold_d        = hold_q;
        hold_v_d      = hold_v_q;
        last_pushed_d = last_pushed_q;
        wcnt_d        = wcnt_q;
        req_int       = 1'b0;
        addr          = '0;
        push          = 1'b0;
        push_data     = hold_q;
        push_last     = 1'b0;
        push_bits     = '0;
        clear         = 1'b0;
        outstanding   = 1'b0;

        if (state_q != StIdle && end_interrupt) eof_seen_d = 1'b1;
        if (pop && wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StPollReq;
                    err_d      = 1'b0;
                    eof_seen_d = 1'b0;
                    wcnt_d     = '0;
                    hold_v_d   = 1'b0;
                    clear      = 1'b1;
                end
            end
            StPollReq: begin
                req_int = 1'b1;
                addr    = BASE_ADDR + 32'h200;
                if (gnt) begin
                    eof_at_poll_d = eof_seen_q;
                    state_d       = StPollWait;
                end
            end
            StPollWait: begin
                if (rsp) begin
                    if (r_rdata[4:0] != 5'd0) begin
                        remaining_d = r_rdata[4:0];
                        state_d     = StDataReq;
                    end else if (eof_at_poll_q) begin
                        state_d = StEndReq;
                    end else begin
                        state_d = StPollReq;
                    end
                end
            end
            StDataReq: begin
                // Only request when the word that the response displaces has somewhere to go.
                if (fifo_free) begin
                    req_int = 1'b1;
                    addr    = BASE_ADDR;
                    if (gnt) state_d = StDataWait;
                end
            end
            StDataWait: begin
                if (rsp) begin
                    hold_d      = r_rdata;
                    hold_v_d    = 1'b1;
                    push        = hold_v_q;
                    remaining_d = remaining_q - 5'd1;
                    state_d     = (remaining_q == 5'd1) ? StPollReq : StDataReq;
                end
            end
            StEndReq: begin
                req_int = 1'b1;
                addr    = BASE_ADDR + 32'h300;
                if (gnt) state_d = StEndWait;
            end
            StEndWait: begin
                if (rsp) begin
                    eof_bits_d    = r_rdata[4:0];
                    last_pushed_d = 1'b0;
                    state_d       = StFlush;
                end
            end
            StFlush: begin
                if (!last_pushed_q && fifo_free) begin
                    push          = 1'b1;
                    push_data     = hold_v_q ? hold_q : 32'h0;
                    push_last     = 1'b1;
                    push_bits     = hold_v_q ? eof_bits_q : 5'd0;
                    hold_v_d      = 1'b0;
                    last_pushed_d = 1'b1;
                end
                if (pop && m_last) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StAbort: begin
                if (rsp) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort: drop everything, but linger in StAbort until an in-flight read returns.
        if (state_q != StIdle && error_interrupt) begin
            err_d    = 1'b1;
            clear    = 1'b1;
            push     = 1'b0;
            hold_v_d = 1'b0;
            done_d   = 1'b0;
            unique case (state_q)
                StPollReq, StDataReq, StEndReq:            outstanding = req_int && gnt;
                StPollWait, StDataWait, StEndWait, StAbort: outstanding = !rsp;
                default:                                    outstanding = 1'b0;
            endcase
            state_d = outstanding ? StAbort : StIdle;
        end

        mem_d    = mem_q;
        last_d   = last_q;
        bits_d   = bits_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q]  = push_data;
            last_d[wr_ptr_q] = push_last;
            bits_d[wr_ptr_q] = push_bits;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            eof_seen_q    <= 1'b0;
            eof_at_poll_q <= 1'b0;
            remaining_q   <= '0;
            eof_bits_q    <= '0;
            hold_q        <= '0;
            hold_v_q      <= 1'b0;
            last_pushed_q <= 1'b0;
            wcnt_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            err_q         <= err_d;
            done_q        <= done_d;
            eof_seen_q    <= eof_seen_d;
            eof_at_poll_q <= eof_at_poll_d;
            remaining_q   <= remaining_d;
            eof_bits_q    <= eof_bits_d;
            hold_q        <= hold_d;
            hold_v_q      <= hold_v_d;
            last_pushed_q <= last_pushed_d;
            wcnt_q        <= wcnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    // Payload storage needs no reset: every read of it is qualified by the entry count.
    always_ff @(posedge clk) begin
        mem_q  <= mem_d;
        last_q <= last_d;
        bits_q <= bits_d;
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign err         = err_q;
    assign req         = req_int;
    assign add         = addr;
    assign wen         = 1'b1;
    assign wdata       = '0;
    assign be          = 4'hF;
    assign id          = MASTER_ID;
    assign m_data      = m_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign m_last      = m_valid && last_q[rd_ptr_q];
    assign m_last_bits = m_valid ? bits_q[rd_ptr_q] : 5'd0;
    assign word_count  = wcnt_q;

endmodule

// File: tb/tb_jpeg_stream_reader.sv
// Directed bench for jpeg_stream_reader: a scripted encoder/bus responder on the
// falling edge, plus per-scenario tasks with hand-computed expectations.
module tb_jpeg_stream_reader;

    localparam logic [31:0] B   = 32'h4000_0000;
    localparam logic [3:0]  MID = 4'h3;

    logic        clk = 1'b0;
    logic        rst, start, end_interrupt, error_interrupt;
    logic        busy, done, err, req, wen, gnt, r_valid;
    logic [31:0] add, wdata, r_rdata, m_data;
    logic [3:0]  be, id, r_id;
    logic        m_valid, m_last, m_ready;
    logic [4:0]  m_last_bits;
    logic [15:0] word_count;

    jpeg_stream_reader #(.BASE_ADDR(B), .ID_W(4), .MASTER_ID(MID), .OUT_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .end_interrupt(end_interrupt), .error_interrupt(error_interrupt),
        .req(req), .add(add), .wen(wen), .wdata(wdata), .be(be), .id(id),
        .gnt(gnt), .r_valid(r_valid), .r_rdata(r_rdata), .r_id(r_id),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_last_bits(m_last_bits),
        .m_ready(m_ready), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Scenario configuration, written only by the test tasks.
    int          depth_tab [8];
    logic [31:0] data_tab [16];
    logic [31:0] end_val;
    int          eoi_poll, resp_delay, eoi_req, clr_req;
    logic        rdy_ctl;

    // Responder state and logs, written only by the responder.
    int          pend_cnt, depth_i, data_i, poll_n, eoi_ack, clr_ack, done_cnt;
    logic [31:0] pend_addr;
    logic [31:0] addr_log [$];
    logic [31:0] beat_d [$];
    logic        beat_l [$];
    logic [4:0]  beat_b [$];

    int n_cmp, n_err;

    initial begin
        pend_cnt = 0; depth_i = 0; data_i = 0; poll_n = 0; eoi_ack = 0; clr_ack = 0;
        done_cnt = 0; pend_addr = '0;
    end

    always @(negedge clk) begin
        m_ready       = rdy_ctl;
        end_interrupt = (eoi_req != eoi_ack);
        eoi_ack       = eoi_req;
        if (clr_req != clr_ack) begin
            clr_ack = clr_req; depth_i = 0; data_i = 0; poll_n = 0;
        end
        r_valid = 1'b0;
        r_rdata = '0;
        r_id    = MID;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                r_valid = 1'b1;
                if (pend_addr == B + 32'h200) begin
                    r_rdata = (depth_i < 8) ? 32'(depth_tab[depth_i]) : 32'h0;
                    depth_i++;
                    poll_n++;
                    if (poll_n == eoi_poll) end_interrupt = 1'b1;
                end else if (pend_addr == B) begin
                    r_rdata = data_tab[data_i % 16];
                    data_i++;
                end else begin
                    r_rdata = end_val;
                end
            end
        end
        if (req && gnt) begin
            addr_log.push_back(add);
            pend_cnt  = 1 + resp_delay;
            pend_addr = add;
        end
        if (m_valid && m_ready) begin
            beat_d.push_back(m_data);
            beat_l.push_back(m_last);
            beat_b.push_back(m_last_bits);
        end
        if (done) done_cnt++;
    end

    task automatic configure(input int d0, input int d1, input logic [31:0] dbase,
                             input logic [31:0] ev, input int ep, input int rd, input logic rdy);
        for (int i = 0; i < 8; i++) depth_tab[i] = 0;
        depth_tab[0] = d0;
        depth_tab[1] = d1;
        for (int i = 0; i < 16; i++) data_tab[i] = dbase + 32'(i);
        end_val = ev; eoi_poll = ep; resp_delay = rd; rdy_ctl = rdy;
        clr_req++;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string name);
        int n;
        n = 0;
        while (done_cnt == base && n < 400) begin @(negedge clk); n++; end
        n_cmp++;
        if (done_cnt == base) begin
            n_err++; $display("FAIL %s_done_timeout: got no done, want done within 400 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp += 12;
        if (busy !== 1'b0)          begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (done !== 1'b0)          begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
        if (err !== 1'b0)           begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
        if (req !== 1'b0)           begin n_err++; $display("FAIL rst_req: got %b want 0", req); end
        if (add !== 32'h0)          begin n_err++; $display("FAIL rst_add: got %h want 0", add); end
        if (m_valid !== 1'b0)       begin n_err++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        if (m_last !== 1'b0)        begin n_err++; $display("FAIL rst_m_last: got %b want 0", m_last); end
        if (m_last_bits !== 5'd0)   begin n_err++; $display("FAIL rst_bits: got %h want 0", m_last_bits); end
        if (word_count !== 16'd0)   begin n_err++; $display("FAIL rst_wc: got %h want 0", word_count); end
        if (wen !== 1'b1)           begin n_err++; $display("FAIL rst_wen: got %b want 1", wen); end
        if (be !== 4'hF)            begin n_err++; $display("FAIL rst_be: got %h want f", be); end
        if (id !== MID)             begin n_err++; $display("FAIL rst_id: got %h want %h", id, MID); end
    endtask

    task automatic test_basic();
        int ab, bb, db;
        logic [31:0] exp_a [6];
        logic [31:0] exp_d [3];
        logic [4:0]  exp_b [3];
        exp_a = '{B + 32'h200, B, B, B, B + 32'h200, B + 32'h300};
        exp_d = '{32'hA, 32'hB, 32'hC};
        exp_b = '{5'd0, 5'd0, 5'd17};
        configure(3, 0, 32'hA, 32'd17, 1, 0, 1'b1);
        ab = addr_log.size(); bb = beat_d.size(); db = done_cnt;
        do_start();
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_done(db, "basic");
        n_cmp += 4;
        if (busy !== 1'b0)        begin n_err++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        if (word_count !== 16'd3) begin n_err++; $display("FAIL basic_wc: got %0d want 3", word_count); end
        if (beat_d.size() - bb != 3)
            begin n_err++; $display("FAIL basic_beats: got %0d want 3", beat_d.size() - bb); end
        if (addr_log.size() - ab != 6)
            begin n_err++; $display("FAIL basic_reads: got %0d want 6", addr_log.size() - ab); end
        for (int i = 0; i < 3 && bb + i < beat_d.size(); i++) begin
            n_cmp += 3;
            if (beat_d[bb+i] !== exp_d[i])
                begin n_err++; $display("FAIL basic_data%0d: got %h want %h", i, beat_d[bb+i], exp_d[i]); end
            if (beat_l[bb+i] !== (i == 2))
                begin n_err++; $display("FAIL basic_last%0d: got %b want %b", i, beat_l[bb+i], i == 2); end
            if (beat_b[bb+i] !== exp_b[i])
                begin n_err++; $display("FAIL basic_bits%0d: got %0d want %0d", i, beat_b[bb+i], exp_b[i]); end
        end
        for (int i = 0; i < 6 && ab + i < addr_log.size(); i++) begin
            n_cmp++;
            if (addr_log[ab+i] !== exp_a[i])
                begin n_err++; $display("FAIL basic_addr%0d: got %h want %h", i, addr_log[ab+i], exp_a[i]); end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_eof_race();
        int ab, bb, db;
        logic [31:0] exp_a [3];
        exp_a = '{B + 32'h200, B + 32'h200, B + 32'h300};
        configure(0, 0, 32'h0, 32'd9, 1, 0, 1'b1);
        ab = addr_log.size(); bb = beat_d.size(); db = done_cnt;
        do_start();
        wait_done(db, "race");
        n_cmp += 2;
        if (addr_log.size() - ab != 3)
            begin n_err++; $display("FAIL race_reads: got %0d want 3", addr_log.size() - ab); end
        if (beat_d.size() - bb != 1)
            begin n_err++; $display("FAIL race_beats: got %0d want 1", beat_d.size() - bb); end
        for (int i = 0; i < 3 && ab + i < addr_log.size(); i++) begin
            n_cmp++;
            if (addr_log[ab+i] !== exp_a[i])
                begin n_err++; $display("FAIL race_addr%0d: got %h want %h", i, addr_log[ab+i], exp_a[i]); end
        end
    endtask

    task automatic test_empty();
        int bb, db;
        configure(0, 0, 32'h0, 32'd0, 0, 0, 1'b1);
        bb = beat_d.size(); db = done_cnt;
        do_start();
        eoi_req++;
        wait_done(db, "empty");
        n_cmp++;
        if (beat_d.size() - bb != 1) begin
            n_err++; $display("FAIL empty_beats: got %0d want 1", beat_d.size() - bb);
        end else begin
            n_cmp += 3;
            if (beat_d[bb] !== 32'h0) begin n_err++; $display("FAIL empty_data: got %h want 0", beat_d[bb]); end
            if (beat_l[bb] !== 1'b1)  begin n_err++; $display("FAIL empty_last: got %b want 1", beat_l[bb]); end
            if (beat_b[bb] !== 5'd0)  begin n_err++; $display("FAIL empty_bits: got %0d want 0", beat_b[bb]); end
        end
    endtask

    task automatic test_backpressure();
        int ab, bb, db, nd;
        configure(10, 0, 32'h100, 32'd5, 1, 0, 1'b0);
        ab = addr_log.size(); bb = beat_d.size(); db = done_cnt;
        do_start();
        repeat (80) @(negedge clk);
        nd = 0;
        for (int i = ab; i < addr_log.size(); i++) if (addr_log[i] == B) nd++;
        n_cmp += 4;
        if (nd != 5)             begin n_err++; $display("FAIL bp_reads: got %0d want 5", nd); end
        if (req !== 1'b0)        begin n_err++; $display("FAIL bp_req_low: got %b want 0", req); end
        if (m_valid !== 1'b1)    begin n_err++; $display("FAIL bp_valid: got %b want 1", m_valid); end
        if (m_data !== 32'h100)  begin n_err++; $display("FAIL bp_head: got %h want 100", m_data); end
        repeat (5) @(negedge clk);
        n_cmp += 2;
        if (m_data !== 32'h100)  begin n_err++; $display("FAIL bp_stable: got %h want 100", m_data); end
        if (m_last !== 1'b0)     begin n_err++; $display("FAIL bp_last_stable: got %b want 0", m_last); end
        rdy_ctl = 1'b1;
        wait_done(db, "bp");
        n_cmp += 2;
        if (word_count !== 16'd10) begin n_err++; $display("FAIL bp_wc: got %0d want 10", word_count); end
        if (beat_d.size() - bb != 10)
            begin n_err++; $display("FAIL bp_beats: got %0d want 10", beat_d.size() - bb); end
        for (int i = 0; i < 10 && bb + i < beat_d.size(); i++) begin
            n_cmp += 3;
            if (beat_d[bb+i] !== 32'h100 + 32'(i))
                begin n_err++; $display("FAIL bp_data%0d: got %h want %h", i, beat_d[bb+i], 32'h100 + 32'(i)); end
            if (beat_l[bb+i] !== (i == 9))
                begin n_err++; $display("FAIL bp_last%0d: got %b want %b", i, beat_l[bb+i], i == 9); end
            if (beat_b[bb+i] !== ((i == 9) ? 5'd5 : 5'd0))
                begin n_err++; $display("FAIL bp_bits%0d: got %0d want %0d", i, beat_b[bb+i], (i == 9) ? 5 : 0); end
        end
    endtask

    task automatic test_error();
        int ab, db, nd, n;
        configure(6, 0, 32'h200, 32'd0, 0, 3, 1'b0);
        ab = addr_log.size(); db = done_cnt;
        do_start();
        nd = 0; n = 0;
        while (nd < 3 && n < 200) begin
            @(negedge clk); n++;
            nd = 0;
            for (int i = ab; i < addr_log.size(); i++) if (addr_log[i] == B) nd++;
        end
        @(negedge clk);
        n_cmp++;
        if (m_valid !== 1'b1) begin n_err++; $display("FAIL err_pre_valid: got %b want 1", m_valid); end
        error_interrupt = 1'b1;
        @(negedge clk);
        error_interrupt = 1'b0;
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        n_cmp += 5;
        if (busy !== 1'b0)    begin n_err++; $display("FAIL err_busy: got %b want 0", busy); end
        if (err !== 1'b1)     begin n_err++; $display("FAIL err_flag: got %b want 1", err); end
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL err_flushed: got %b want 0", m_valid); end
        if (req !== 1'b0)     begin n_err++; $display("FAIL err_req: got %b want 0", req); end
        if (done_cnt != db)   begin n_err++; $display("FAIL err_no_done: got %0d want 0", done_cnt - db); end
        repeat (8) @(negedge clk);
        configure(0, 0, 32'h0, 32'd0, 0, 0, 1'b1);
        db = done_cnt;
        do_start();
        eoi_req++;
        n_cmp++;
        if (err !== 1'b0) begin n_err++; $display("FAIL err_cleared: got %b want 0", err); end
        wait_done(db, "err_restart");
    endtask

    task automatic test_reset_mid();
        int ab, bb, n;
        configure(4, 0, 32'h300, 32'd0, 0, 3, 1'b1);
        ab = addr_log.size(); bb = beat_d.size();
        do_start();
        n = 0;
        while (addr_log.size() - ab < 2 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp += 6;
        if (busy !== 1'b0)        begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (req !== 1'b0)         begin n_err++; $display("FAIL mid_req: got %b want 0", req); end
        if (add !== 32'h0)        begin n_err++; $display("FAIL mid_add: got %h want 0", add); end
        if (m_valid !== 1'b0)     begin n_err++; $display("FAIL mid_valid: got %b want 0", m_valid); end
        if (err !== 1'b0)         begin n_err++; $display("FAIL mid_err: got %b want 0", err); end
        if (word_count !== 16'd0) begin n_err++; $display("FAIL mid_wc: got %0d want 0", word_count); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp += 3;
        if (beat_d.size() != bb) begin n_err++; $display("FAIL mid_late_beat: got %0d want 0", beat_d.size() - bb); end
        if (m_valid !== 1'b0)    begin n_err++; $display("FAIL mid_valid_late: got %b want 0", m_valid); end
        if (busy !== 1'b0)       begin n_err++; $display("FAIL mid_busy_late: got %b want 0", busy); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; error_interrupt = 1'b0; gnt = 1'b1;
        end_val = '0; eoi_poll = 0; resp_delay = 0; eoi_req = 0; clr_req = 0; rdy_ctl = 1'b0;
        for (int i = 0; i < 8; i++) depth_tab[i] = 0;
        for (int i = 0; i < 16; i++) data_tab[i] = '0;
        test_reset();
        test_basic();
        test_eof_race();
        test_empty();
        test_backpressure();
        test_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
